banzai_axil_master_arb: RTL and testbench

BANZAI_AXIL_MASTER_ARB -- requirements
Module: banzai_axil_master_arb

---
 rtl/banzai_pkg.sv | 34 +++
 rtl/banzai_rr_arb2.sv | 43 ++++
 rtl/banzai_axil_master_arb.sv | 191 +++++++++++++++++++
 tb/tb_banzai_axil_master_arb.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/banzai_pkg.sv
// banzai_pkg
// Shared definitions for the banzai AXI-Lite master arbiter: the transaction
// FSM state encoding, AXI response codes, the fixed protection value and a
// helper that classifies a response code as an error.
package banzai_pkg;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_WR_ADDR_DATA = 3'd1,
        ST_WR_RESP      = 3'd2,
        ST_RD_ADDR      = 3'd3,
        ST_RD_DATA      = 3'd4
    } state_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

    // SLVERR and DECERR both carry resp[1]=1; those are the failing codes.
    function automatic logic resp_is_err(input logic [1:0] resp);
        logic err;
        err = 1'b0;
        case (resp)
            AXI_RESP_SLVERR, AXI_RESP_DECERR: err = 1'b1;
            AXI_RESP_OKAY, AXI_RESP_EXOKAY:   err = 1'b0;
            default:                          err = 1'b0;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/banzai_rr_arb2.sv
// banzai_rr_arb2
// Two-way round-robin arbiter. The grant is combinational from the request
// vector and a one-bit pointer holding the last requester granted; the
// pointer advances whenever the owner of the arbiter consumes a grant.
//
// Ports
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset (pointer set so requester 0 wins
//           the first tie)
//   req   : request vector, bit n = requester n
//   take  : the current grant is being used this cycle
//   grant : one-hot grant, zero when nothing is requested
module banzai_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] grant
);

    logic last_q;

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Pointer starts at 1 so that requester 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (take && (grant != 2'b00)) begin
            last_q <= grant[1];
        end
    end

endmodule

// File: rtl/banzai_axil_master_arb.sv
// banzai_axil_master_arb
// Arbitrates two simple request/response clients onto one AXI-Lite master
// port with at most one transaction outstanding.
//
// Ports
//   clk_i, rst_i            : clock and asynchronous active-high reset
//   req_valid_i/req_ready_o : per-requester request handshake (bit n = req n)
//   req_we_i                : per-requester write enable (1 = write)
//   req_addr_i              : per-requester address, requester n at [32n +: 32]
//   req_wdata_i             : per-requester write data, requester n at [32n +: 32]
//   req_wstrb_i             : per-requester write strobes, requester n at [4n +: 4]
//   rsp_valid_o             : per-requester one-cycle response pulse
//   rsp_rdata_o, rsp_err_o  : shared response payload, valid with rsp_valid_o
//   axi_master_*            : AXI-Lite AW, W, B, AR and R channels
module banzai_axil_master_arb
    import banzai_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  req_valid_i,
    output logic [1:0]  req_ready_o,
    input  logic [1:0]  req_we_i,
    input  logic [63:0] req_addr_i,
    input  logic [63:0] req_wdata_i,
    input  logic [7:0]  req_wstrb_i,
    output logic [1:0]  rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic [31:0] axi_master_awaddr_o,
    output logic [2:0]  axi_master_awprot_o,
    output logic        axi_master_awvalid_o,
    input  logic        axi_master_awready_i,
    output logic [31:0] axi_master_wdata_o,
    output logic [3:0]  axi_master_wstrb_o,
    output logic        axi_master_wvalid_o,
    input  logic        axi_master_wready_i,
    input  logic [1:0]  axi_master_bresp_i,
    input  logic        axi_master_bvalid_i,
    output logic        axi_master_bready_o,
    output logic [31:0] axi_master_araddr_o,
    output logic [2:0]  axi_master_arprot_o,
    output logic        axi_master_arvalid_o,
    input  logic        axi_master_arready_i,
    input  logic [31:0] axi_master_rdata_i,
    input  logic [1:0]  axi_master_rresp_i,
    input  logic        axi_master_rvalid_i,
    output logic        axi_master_rready_o
);

    state_t      state_q, state_d;
    logic [1:0]  grant;
    logic        accept;
    logic        owner_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        aw_done_q, w_done_q;
    logic        aw_hs, w_hs, b_hs, r_hs;
    logic        sel_we;
    logic [31:0] sel_addr, sel_wdata;
    logic [3:0]  sel_wstrb;

    banzai_rr_arb2 u_arb (
        .clk   (clk_i),
        .rst   (rst_i),
        .req   (req_valid_i),
        .take  (accept),
        .grant (grant)
    );

    // Payload of whichever requester the arbiter currently favours.
    assign sel_we    = grant[1] ? req_we_i[1]          : req_we_i[0];
    assign sel_addr  = grant[1] ? req_addr_i[63:32]    : req_addr_i[31:0];
    assign sel_wdata = grant[1] ? req_wdata_i[63:32]   : req_wdata_i[31:0];
    assign sel_wstrb = grant[1] ? req_wstrb_i[7:4]     : req_wstrb_i[3:0];

    // Channel valids/readies come straight from the state so that an
    // asynchronous reset clears them in the same cycle.
    assign axi_master_awvalid_o = (state_q == ST_WR_ADDR_DATA) && !aw_done_q;
    assign axi_master_wvalid_o  = (state_q == ST_WR_ADDR_DATA) && !w_done_q;
    assign axi_master_bready_o  = (state_q == ST_WR_RESP);
    assign axi_master_arvalid_o = (state_q == ST_RD_ADDR);
    assign axi_master_rready_o  = (state_q == ST_RD_DATA);

    assign axi_master_awaddr_o = addr_q;
    assign axi_master_araddr_o = addr_q;
    assign axi_master_wdata_o  = wdata_q;
    assign axi_master_wstrb_o  = wstrb_q;
    assign axi_master_awprot_o = AXI_PROT_DEFAULT;
    assign axi_master_arprot_o = AXI_PROT_DEFAULT;

    assign aw_hs = axi_master_awvalid_o && axi_master_awready_i;
    assign w_hs  = axi_master_wvalid_o  && axi_master_wready_i;
    assign b_hs  = axi_master_bready_o  && axi_master_bvalid_i;
    assign r_hs  = axi_master_rready_o  && axi_master_rvalid_i;

    // req_ready is combinational from req_valid, so gate it with reset to
    // keep it low while reset is held.
    assign req_ready_o = (accept && !rst_i) ? grant : 2'b00;

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. AW and W complete independently; the write moves on
    // once both have completed, counting a handshake happening this cycle.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i != 2'b00) begin
                    accept  = 1'b1;
                    state_d = sel_we ? ST_WR_ADDR_DATA : ST_RD_ADDR;
                end
            end
            ST_WR_ADDR_DATA: begin
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    state_d = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (b_hs) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_ADDR: begin
                if (axi_master_arready_i) begin
                    state_d = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (r_hs) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Transaction capture, channel completion flags and the response pulse.
    // The request is latched at accept so the requester may drop it freely.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            wstrb_q     <= 4'd0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rsp_valid_o <= 2'b00;
            rsp_rdata_o <= 32'd0;
            rsp_err_o   <= 1'b0;
        end else begin
            rsp_valid_o <= 2'b00;
            if (accept) begin
                owner_q   <= grant[1];
                we_q      <= sel_we;
                addr_q    <= sel_addr;
                wdata_q   <= sel_wdata;
                wstrb_q   <= sel_wstrb;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end
            if (aw_hs) begin
                aw_done_q <= 1'b1;
            end
            if (w_hs) begin
                w_done_q <= 1'b1;
            end
            if (b_hs && we_q) begin
                rsp_valid_o <= owner_q ? 2'b10 : 2'b01;
                rsp_err_o   <= resp_is_err(axi_master_bresp_i);
                rsp_rdata_o <= 32'd0;
            end
            if (r_hs && !we_q) begin
                rsp_valid_o <= owner_q ? 2'b10 : 2'b01;
                rsp_err_o   <= resp_is_err(axi_master_rresp_i);
                rsp_rdata_o <= axi_master_rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_banzai_axil_master_arb.sv
// tb_banzai_axil_master_arb
// Self-checking bench for banzai_axil_master_arb. Inputs change and outputs
// are sampled on the falling clock edge. A small reference model tracks the
// last granted requester and predicts grants, channel activity and responses.
module tb_banzai_axil_master_arb;
    import banzai_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  req_valid_i;
    logic [1:0]  req_ready_o;
    logic [1:0]  req_we_i;
    logic [63:0] req_addr_i;
    logic [63:0] req_wdata_i;
    logic [7:0]  req_wstrb_i;
    logic [1:0]  rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic [31:0] axi_master_awaddr_o;
    logic [2:0]  axi_master_awprot_o;
    logic        axi_master_awvalid_o;
    logic        axi_master_awready_i;
    logic [31:0] axi_master_wdata_o;
    logic [3:0]  axi_master_wstrb_o;
    logic        axi_master_wvalid_o;
    logic        axi_master_wready_i;
    logic [1:0]  axi_master_bresp_i;
    logic        axi_master_bvalid_i;
    logic        axi_master_bready_o;
    logic [31:0] axi_master_araddr_o;
    logic [2:0]  axi_master_arprot_o;
    logic        axi_master_arvalid_o;
    logic        axi_master_arready_i;
    logic [31:0] axi_master_rdata_i;
    logic [1:0]  axi_master_rresp_i;
    logic        axi_master_rvalid_i;
    logic        axi_master_rready_o;

    int errors = 0;
    int checks = 0;
    int last_gnt = 1;

    banzai_axil_master_arb dut (
        .clk_i                (clk_i),
        .rst_i                (rst_i),
        .req_valid_i          (req_valid_i),
        .req_ready_o          (req_ready_o),
        .req_we_i             (req_we_i),
        .req_addr_i           (req_addr_i),
        .req_wdata_i          (req_wdata_i),
        .req_wstrb_i          (req_wstrb_i),
        .rsp_valid_o          (rsp_valid_o),
        .rsp_rdata_o          (rsp_rdata_o),
        .rsp_err_o            (rsp_err_o),
        .axi_master_awaddr_o  (axi_master_awaddr_o),
        .axi_master_awprot_o  (axi_master_awprot_o),
        .axi_master_awvalid_o (axi_master_awvalid_o),
        .axi_master_awready_i (axi_master_awready_i),
        .axi_master_wdata_o   (axi_master_wdata_o),
        .axi_master_wstrb_o   (axi_master_wstrb_o),
        .axi_master_wvalid_o  (axi_master_wvalid_o),
        .axi_master_wready_i  (axi_master_wready_i),
        .axi_master_bresp_i   (axi_master_bresp_i),
        .axi_master_bvalid_i  (axi_master_bvalid_i),
        .axi_master_bready_o  (axi_master_bready_o),
        .axi_master_araddr_o  (axi_master_araddr_o),
        .axi_master_arprot_o  (axi_master_arprot_o),
        .axi_master_arvalid_o (axi_master_arvalid_o),
        .axi_master_arready_i (axi_master_arready_i),
        .axi_master_rdata_i   (axi_master_rdata_i),
        .axi_master_rresp_i   (axi_master_rresp_i),
        .axi_master_rvalid_i  (axi_master_rvalid_i),
        .axi_master_rready_o  (axi_master_rready_o)
    );

    always #5 clk_i = ~clk_i;

    // Hard time limit so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "[TB] time limit reached");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h required=%0h", tag, obs, exp);
        end
    endtask

    // Round-robin reference: on a tie, the requester not granted last wins.
    function automatic int expGrant(input logic [1:0] mask);
        if (mask == 2'b11) return (last_gnt == 0) ? 1 : 0;
        if (mask[1]) return 1;
        return 0;
    endfunction

    // One full transaction. The predicted winner gets the given payload; the
    // other requester gets the complemented payload so a wrong mux shows up.
    // With hold=1 the request stays asserted and the task returns at the
    // response cycle, so the next call's grant lands back-to-back.
    task automatic applyStimulus(input logic [1:0] mask, input logic we,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] wstrb, input int a_dly, input int w_dly,
                                 input int r_dly, input logic [1:0] resp,
                                 input logic [31:0] rdata, input bit hold);
        int g;
        int aw_cnt;
        int w_cnt;
        int top;
        g = expGrant(mask);
        for (int n = 0; n < 2; n++) begin
            if (n == g) begin
                req_we_i[n]            = we;
                req_addr_i[n*32 +: 32] = addr;
                req_wdata_i[n*32 +: 32] = wdata;
                req_wstrb_i[n*4 +: 4]  = wstrb;
            end else begin
                req_we_i[n]            = ~we;
                req_addr_i[n*32 +: 32] = ~addr;
                req_wdata_i[n*32 +: 32] = ~wdata;
                req_wstrb_i[n*4 +: 4]  = ~wstrb;
            end
        end
        req_valid_i = mask;
        #1;
        checkOutput("req_ready", {62'd0, req_ready_o}, (g == 1) ? 64'd2 : 64'd1);
        last_gnt = g;
        @(negedge clk_i);
        if (!hold) req_valid_i = 2'b00;
        checkOutput("req_ready_busy", {62'd0, req_ready_o}, 64'd0);
        if (we) begin
            aw_cnt = 0;
            w_cnt  = 0;
            top = (a_dly > w_dly) ? a_dly : w_dly;
            for (int k = 0; k <= top; k++) begin
                if (k > 0) @(negedge clk_i);
                checkOutput("awvalid", {63'd0, axi_master_awvalid_o}, (k <= a_dly) ? 64'd1 : 64'd0);
                checkOutput("wvalid", {63'd0, axi_master_wvalid_o}, (k <= w_dly) ? 64'd1 : 64'd0);
                if (k <= a_dly) checkOutput("awaddr", {32'd0, axi_master_awaddr_o}, {32'd0, addr});
                if (k <= w_dly) begin
                    checkOutput("wdata", {32'd0, axi_master_wdata_o}, {32'd0, wdata});
                    checkOutput("wstrb", {60'd0, axi_master_wstrb_o}, {60'd0, wstrb});
                end
                checkOutput("bready_early", {63'd0, axi_master_bready_o}, 64'd0);
                checkOutput("arvalid_wr", {63'd0, axi_master_arvalid_o}, 64'd0);
                axi_master_awready_i = (k >= a_dly);
                axi_master_wready_i  = (k >= w_dly);
                axi_master_bvalid_i  = 1'($urandom_range(0, 1));
                axi_master_bresp_i   = AXI_RESP_SLVERR;
                axi_master_rvalid_i  = 1'($urandom_range(0, 1));
                axi_master_rresp_i   = AXI_RESP_DECERR;
                if (axi_master_awvalid_o && axi_master_awready_i) aw_cnt++;
                if (axi_master_wvalid_o && axi_master_wready_i) w_cnt++;
            end
            @(negedge clk_i);
            axi_master_awready_i = 1'b0;
            axi_master_wready_i  = 1'b0;
            checkOutput("aw_handshakes", 64'(aw_cnt), 64'd1);
            checkOutput("w_handshakes", 64'(w_cnt), 64'd1);
            for (int k = 0; k <= r_dly; k++) begin
                if (k > 0) @(negedge clk_i);
                checkOutput("bready", {63'd0, axi_master_bready_o}, 64'd1);
                checkOutput("awvalid_resp", {63'd0, axi_master_awvalid_o}, 64'd0);
                checkOutput("wvalid_resp", {63'd0, axi_master_wvalid_o}, 64'd0);
                axi_master_bvalid_i = (k == r_dly);
                axi_master_bresp_i  = (k == r_dly) ? resp : 2'($urandom_range(0, 3));
                axi_master_rvalid_i = 1'($urandom_range(0, 1));
            end
        end else begin
            for (int k = 0; k <= a_dly; k++) begin
                if (k > 0) @(negedge clk_i);
                checkOutput("arvalid", {63'd0, axi_master_arvalid_o}, 64'd1);
                checkOutput("araddr", {32'd0, axi_master_araddr_o}, {32'd0, addr});
                checkOutput("rready_early", {63'd0, axi_master_rready_o}, 64'd0);
                checkOutput("awvalid_rd", {63'd0, axi_master_awvalid_o}, 64'd0);
                axi_master_arready_i = (k == a_dly);
                axi_master_rvalid_i  = 1'($urandom_range(0, 1));
                axi_master_rresp_i   = AXI_RESP_SLVERR;
                axi_master_rdata_i   = $urandom;
                axi_master_bvalid_i  = 1'($urandom_range(0, 1));
            end
            @(negedge clk_i);
            axi_master_arready_i = 1'b0;
            for (int k = 0; k <= r_dly; k++) begin
                if (k > 0) @(negedge clk_i);
                checkOutput("rready", {63'd0, axi_master_rready_o}, 64'd1);
                checkOutput("arvalid_data", {63'd0, axi_master_arvalid_o}, 64'd0);
                axi_master_rvalid_i = (k == r_dly);
                axi_master_rresp_i  = (k == r_dly) ? resp : 2'($urandom_range(0, 3));
                axi_master_rdata_i  = (k == r_dly) ? rdata : $urandom;
                axi_master_bvalid_i = 1'($urandom_range(0, 1));
            end
        end
        @(negedge clk_i);
        axi_master_bvalid_i = 1'b0;
        axi_master_rvalid_i = 1'b0;
        checkOutput("rsp_valid", {62'd0, rsp_valid_o}, (g == 1) ? 64'd2 : 64'd1);
        checkOutput("rsp_err", {63'd0, rsp_err_o}, (int'(resp) >= 2) ? 64'd1 : 64'd0);
        checkOutput("rsp_rdata", {32'd0, rsp_rdata_o}, we ? 64'd0 : {32'd0, rdata});
        checkOutput("bready_idle", {63'd0, axi_master_bready_o}, 64'd0);
        checkOutput("rready_idle", {63'd0, axi_master_rready_o}, 64'd0);
        if (!hold) begin
            @(negedge clk_i);
            checkOutput("rsp_pulse_end", {62'd0, rsp_valid_o}, 64'd0);
        end
    endtask

    initial begin
        rst_i                = 1'b1;
        req_valid_i          = 2'b11;
        req_we_i             = 2'b00;
        req_addr_i           = 64'd0;
        req_wdata_i          = 64'd0;
        req_wstrb_i          = 8'd0;
        axi_master_awready_i = 1'b0;
        axi_master_wready_i  = 1'b0;
        axi_master_bresp_i   = AXI_RESP_OKAY;
        axi_master_bvalid_i  = 1'b0;
        axi_master_arready_i = 1'b0;
        axi_master_rdata_i   = 32'd0;
        axi_master_rresp_i   = AXI_RESP_OKAY;
        axi_master_rvalid_i  = 1'b0;

        // Reset state, with both requests raised to show ready stays low.
        repeat (2) @(negedge clk_i);
        checkOutput("rst_req_ready", {62'd0, req_ready_o}, 64'd0);
        checkOutput("rst_awvalid", {63'd0, axi_master_awvalid_o}, 64'd0);
        checkOutput("rst_wvalid", {63'd0, axi_master_wvalid_o}, 64'd0);
        checkOutput("rst_arvalid", {63'd0, axi_master_arvalid_o}, 64'd0);
        checkOutput("rst_bready", {63'd0, axi_master_bready_o}, 64'd0);
        checkOutput("rst_rready", {63'd0, axi_master_rready_o}, 64'd0);
        checkOutput("rst_rsp_valid", {62'd0, rsp_valid_o}, 64'd0);
        checkOutput("rst_rsp_rdata", {32'd0, rsp_rdata_o}, 64'd0);
        checkOutput("rst_rsp_err", {63'd0, rsp_err_o}, 64'd0);
        checkOutput("awprot", {61'd0, axi_master_awprot_o}, 64'd0);
        checkOutput("arprot", {61'd0, axi_master_arprot_o}, 64'd0);
        req_valid_i = 2'b00;
        rst_i = 1'b0;
        last_gnt = 1;
        @(negedge clk_i);

        $display("[TB] single read from requester 0");
        applyStimulus(2'b01, 1'b0, 32'h100, 32'h0, 4'h0, 0, 0, 1, AXI_RESP_OKAY, 32'hDEADBEEF, 1'b0);

        $display("[TB] write from requester 1, AW accepted 3 cycles before W");
        applyStimulus(2'b10, 1'b1, 32'h20, 32'h5A, 4'hF, 0, 3, 0, AXI_RESP_OKAY, 32'h0, 1'b0);

        $display("[TB] write with SLVERR response");
        applyStimulus(2'b10, 1'b1, 32'h44, 32'h1234, 4'h3, 2, 1, 2, AXI_RESP_SLVERR, 32'h0, 1'b0);

        $display("[TB] four back-to-back ties");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'b11, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom),
                          $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                          2'($urandom_range(0, 3)), $urandom, (i < 3));
        end

        $display("[TB] randomized transactions");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(2'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                          4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 3), 2'($urandom_range(0, 3)), $urandom,
                          (i < 15) ? 1'($urandom_range(0, 1)) : 1'b0);
        end

        $display("[TB] reset during read data phase");
        req_we_i    = 2'b00;
        req_addr_i  = {32'h0, 32'h300};
        req_valid_i = 2'b01;
        #1;
        checkOutput("rst_case_grant", {62'd0, req_ready_o}, 64'd1);
        @(negedge clk_i);
        req_valid_i = 2'b00;
        checkOutput("rst_case_arvalid", {63'd0, axi_master_arvalid_o}, 64'd1);
        axi_master_arready_i = 1'b1;
        @(negedge clk_i);
        axi_master_arready_i = 1'b0;
        checkOutput("rst_case_rready", {63'd0, axi_master_rready_o}, 64'd1);
        rst_i = 1'b1;
        #1;
        checkOutput("rst_mid_arvalid", {63'd0, axi_master_arvalid_o}, 64'd0);
        checkOutput("rst_mid_rready", {63'd0, axi_master_rready_o}, 64'd0);
        axi_master_rvalid_i = 1'b1;
        axi_master_rdata_i  = 32'hBAD0BAD0;
        repeat (2) @(negedge clk_i);
        checkOutput("rst_mid_rsp", {62'd0, rsp_valid_o}, 64'd0);
        rst_i = 1'b0;
        last_gnt = 1;
        @(negedge clk_i);
        checkOutput("rst_after_rsp", {62'd0, rsp_valid_o}, 64'd0);
        axi_master_bvalid_i = 1'b1;
        @(negedge clk_i);
        axi_master_rvalid_i = 1'b0;
        axi_master_bvalid_i = 1'b0;
        checkOutput("idle_ignore_rsp", {62'd0, rsp_valid_o}, 64'd0);

        $display("[TB] first tie after reset");
        applyStimulus(2'b11, 1'b0, 32'h400, 32'h0, 4'h0, 1, 0, 0, AXI_RESP_OKAY, 32'hCAFEF00D, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
